// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID/EX pipeline register and the surrounding pipeline.
// slave = the stage itself, master = the pipeline/bench driving it.
interface id_ex_stage_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  stall;
   logic                  flush;
   logic                  id_valid;
   logic [XLEN-1:0]       id_pc;
   logic [XLEN-1:0]       id_rs1_data;
   logic [XLEN-1:0]       id_rs2_data;
   logic [XLEN-1:0]       id_imm;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_uses_rs1;
   logic                  id_uses_rs2;
   logic [3:0]            id_alu_op;
   logic                  id_alu_src;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  id_mem_write;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic                  mem_reg_write;
   logic [XLEN-1:0]       mem_fwd_data;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  wb_reg_write;
   logic [XLEN-1:0]       wb_data;
   logic                  ex_valid;
   logic [XLEN-1:0]       ex_pc;
   logic [XLEN-1:0]       alu_x;
   logic [XLEN-1:0]       alu_y;
   logic [3:0]            alu_op;
   logic [XLEN-1:0]       ex_store_data;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_reg_write;
   logic                  ex_mem_read;
   logic                  ex_mem_write;
   logic                  hazard_stall;

   modport slave (
      input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_alu_op, id_alu_src,
             id_reg_write, id_mem_read, id_mem_write,
             mem_rd, mem_reg_write, mem_fwd_data, wb_rd, wb_reg_write, wb_data,
      output ex_valid, ex_pc, alu_x, alu_y, alu_op, ex_store_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
   );

   modport master (
      output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_alu_op, id_alu_src,
             id_reg_write, id_mem_read, id_mem_write,
             mem_rd, mem_reg_write, mem_fwd_data, wb_rd, wb_reg_write, wb_data,
      input  ex_valid, ex_pc, alu_x, alu_y, alu_op, ex_store_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Build option ID_EX_FWD_EN: defined = EX/MEM and MEM/WB forwarding; undefined = no forwarding, stall on any RAW.
module id_ex_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   id_ex_stage_if.slave  bus
);

   typedef struct packed {
      logic                  valid;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       rs1_data;
      logic [XLEN-1:0]       rs2_data;
      logic [XLEN-1:0]       imm;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [3:0]            alu_op;
      logic                  alu_src;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
   } stage_t;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = {REG_ADDR_W{1'b0}};

   stage_t          stage_q;
   stage_t          stage_d;
   logic            load_use_s;
   logic            hazard_s;
   logic [XLEN-1:0] fwd1_s;
   logic [XLEN-1:0] fwd2_s;

   function automatic logic src_hit(input logic                  uses,
                                    input logic [REG_ADDR_W-1:0] rs,
                                    input logic [REG_ADDR_W-1:0] rd);
      return uses && (rs == rd);
   endfunction

   function automatic logic [XLEN-1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                                input logic [XLEN-1:0]       raw,
                                                input logic                  m_we,
                                                input logic [REG_ADDR_W-1:0] m_rd,
                                                input logic [XLEN-1:0]       m_data,
                                                input logic                  w_we,
                                                input logic [REG_ADDR_W-1:0] w_rd,
                                                input logic [XLEN-1:0]       w_data);
      logic [XLEN-1:0] res;
      if (m_we && (m_rd != REG_X0) && (m_rd == rs)) begin
         res = m_data;
      end else if (w_we && (w_rd != REG_X0) && (w_rd == rs)) begin
         res = w_data;
      end else begin
         res = raw;
      end
      return res;
   endfunction

   // Hazard detection on the live ID instruction against the registered stage
   always_comb begin
      load_use_s = stage_q.valid && stage_q.mem_read && (stage_q.rd != REG_X0) && bus.id_valid &&
                   (src_hit(bus.id_uses_rs1, bus.id_rs1, stage_q.rd) ||
                    src_hit(bus.id_uses_rs2, bus.id_rs2, stage_q.rd));
`ifdef ID_EX_FWD_EN
      hazard_s = load_use_s;
`else
      // Without forwarding any in-flight producer of a used source must drain first
      hazard_s = load_use_s ||
                 (bus.id_valid && stage_q.valid && stage_q.reg_write && (stage_q.rd != REG_X0) &&
                  (src_hit(bus.id_uses_rs1, bus.id_rs1, stage_q.rd) ||
                   src_hit(bus.id_uses_rs2, bus.id_rs2, stage_q.rd))) ||
                 (bus.id_valid && bus.mem_reg_write && (bus.mem_rd != REG_X0) &&
                  (src_hit(bus.id_uses_rs1, bus.id_rs1, bus.mem_rd) ||
                   src_hit(bus.id_uses_rs2, bus.id_rs2, bus.mem_rd)));
`endif
   end

   // Operand select: forwarded or raw registered read data
   always_comb begin
`ifdef ID_EX_FWD_EN
      fwd1_s = fwd_sel(stage_q.rs1, stage_q.rs1_data, bus.mem_reg_write, bus.mem_rd,
                       bus.mem_fwd_data, bus.wb_reg_write, bus.wb_rd, bus.wb_data);
      fwd2_s = fwd_sel(stage_q.rs2, stage_q.rs2_data, bus.mem_reg_write, bus.mem_rd,
                       bus.mem_fwd_data, bus.wb_reg_write, bus.wb_rd, bus.wb_data);
`else
      fwd1_s = stage_q.rs1_data;
      fwd2_s = stage_q.rs2_data;
`endif
   end

   // Next-state priority: flush > stall > hazard bubble > load
   always_comb begin
      stage_d = stage_q;
      if (bus.flush) begin
         stage_d.valid     = 1'b0;
         stage_d.reg_write = 1'b0;
         stage_d.mem_read  = 1'b0;
         stage_d.mem_write = 1'b0;
      end else if (bus.stall) begin
         stage_d = stage_q;
      end else if (hazard_s) begin
         // Operand fields are left as-is; only valid/control matter for a bubble
         stage_d.valid     = 1'b0;
         stage_d.reg_write = 1'b0;
         stage_d.mem_read  = 1'b0;
         stage_d.mem_write = 1'b0;
      end else begin
         stage_d.valid     = bus.id_valid;
         stage_d.pc        = bus.id_pc;
         stage_d.rs1_data  = bus.id_rs1_data;
         stage_d.rs2_data  = bus.id_rs2_data;
         stage_d.imm       = bus.id_imm;
         stage_d.rs1       = bus.id_rs1;
         stage_d.rs2       = bus.id_rs2;
         stage_d.rd        = bus.id_rd;
         stage_d.alu_op    = bus.id_alu_op;
         stage_d.alu_src   = bus.id_alu_src;
         stage_d.reg_write = bus.id_reg_write;
         stage_d.mem_read  = bus.id_mem_read;
         stage_d.mem_write = bus.id_mem_write;
      end
   end

   // Stage register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign bus.ex_valid      = stage_q.valid;
   assign bus.ex_pc         = stage_q.pc;
   assign bus.alu_op        = stage_q.alu_op;
   assign bus.ex_rd         = stage_q.rd;
   assign bus.alu_x         = fwd1_s;
   assign bus.alu_y         = stage_q.alu_src ? stage_q.imm : fwd2_s;
   assign bus.ex_store_data = fwd2_s;
   assign bus.ex_reg_write  = stage_q.reg_write & stage_q.valid;
   assign bus.ex_mem_read   = stage_q.mem_read  & stage_q.valid;
   assign bus.ex_mem_write  = stage_q.mem_write & stage_q.valid;
   assign bus.hazard_stall  = hazard_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the stage outputs.
module tb_id_ex_stage;
   localparam int XLEN = 32;
   localparam int RW   = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   id_ex_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus();

   id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      bit          cd;
      logic        v;
      logic [31:0] pc;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] sd;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        hz;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic cmp(input string n, input string f, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s.%s got %h expected %h", n, f, a, e);
      end
   endtask

   task automatic push(input string n, input bit cd, input logic v, input logic [31:0] pc,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] sd,
                       input logic [3:0] op, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic hz);
      exp_t e;
      e.name = n; e.cd = cd; e.v = v; e.pc = pc; e.x = x; e.y = y; e.sd = sd;
      e.op = op; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw; e.hz = hz;
      sb.push_back(e);
   endtask

   // Monitor: compare every queued expectation mid-cycle
   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cmp(e.name, "ex_valid",     32'(bus.ex_valid),     32'(e.v));
         cmp(e.name, "ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
         cmp(e.name, "ex_mem_read",  32'(bus.ex_mem_read),  32'(e.mr));
         cmp(e.name, "ex_mem_write", 32'(bus.ex_mem_write), 32'(e.mw));
         cmp(e.name, "hazard_stall", 32'(bus.hazard_stall), 32'(e.hz));
         if (e.cd) begin
            cmp(e.name, "ex_pc",         bus.ex_pc,         e.pc);
            cmp(e.name, "alu_x",         bus.alu_x,         e.x);
            cmp(e.name, "alu_y",         bus.alu_y,         e.y);
            cmp(e.name, "ex_store_data", bus.ex_store_data, e.sd);
            cmp(e.name, "alu_op",        32'(bus.alu_op),   32'(e.op));
            cmp(e.name, "ex_rd",         32'(bus.ex_rd),    32'(e.rd));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                         input logic [31:0] r2d, input logic [31:0] imm, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic u1,
                         input logic u2, input logic [3:0] op, input logic src,
                         input logic rw, input logic mr, input logic mw);
      bus.id_valid = v;     bus.id_pc = pc;       bus.id_rs1_data = r1d;
      bus.id_rs2_data = r2d; bus.id_imm = imm;    bus.id_rs1 = r1;
      bus.id_rs2 = r2;      bus.id_rd = rd;       bus.id_uses_rs1 = u1;
      bus.id_uses_rs2 = u2; bus.id_alu_op = op;   bus.id_alu_src = src;
      bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.stall = 1'b0; bus.flush = 1'b0;
      bus.mem_rd = 5'd0; bus.mem_reg_write = 1'b0; bus.mem_fwd_data = 32'd0;
      bus.wb_rd = 5'd0;  bus.wb_reg_write = 1'b0;  bus.wb_data = 32'd0;
      set_id(1'b1, 32'h100, 32'd9, 32'd4, 32'd0, 5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset held two edges with a live ID instruction
      tick();
      push("reset_1", 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      push("reset_2", 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      tick();
      set_id(1'b1, 32'h104, 32'd7, 32'd5, 32'd0, 5'd8, 5'd9, 5'd6, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
      push("post_reset", 1'b1, 1'b1, 32'h100, 32'd9, 32'd4, 32'd4, 4'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);

      tick();
      set_id(1'b1, 32'h108, 32'd3, 32'd5, 32'h100, 5'd11, 5'd12, 5'd10, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      push("plain", 1'b1, 1'b1, 32'h104, 32'd7, 32'd5, 32'd5, 4'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);

      tick();
      set_id(1'b1, 32'h10C, 32'h40, 32'd0, 32'd4, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      push("imm_store", 1'b1, 1'b1, 32'h108, 32'd3, 32'h100, 32'd5, 4'd7, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0);

      // lw x5 in EX, add reading x5 in ID
      tick();
      set_id(1'b1, 32'h110, 32'hAA, 32'hBB, 32'd0, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      push("loaduse_hz", 1'b1, 1'b1, 32'h10C, 32'h40, 32'd4, 32'd0, 4'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      push("loaduse_bubble", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 32'h114, 32'h55, 32'h66, 32'd0, 5'd20, 5'd21, 5'd1, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.stall = 1'b1;
      push("add_capture", 1'b1, 1'b1, 32'h110, 32'hAA, 32'hBB, 32'hBB, 4'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) begin
         tick();
         push("stall_hold", 1'b1, 1'b1, 32'h110, 32'hAA, 32'hBB, 32'hBB, 4'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      bus.flush = 1'b1;
      tick();
      push("flush_over_stall", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.stall = 1'b0; bus.flush = 1'b0;

`ifdef ID_EX_FWD_EN
      set_id(1'b1, 32'h200, 32'h33, 32'h44, 32'd0, 5'd3, 5'd0, 5'd9, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.stall = 1'b1;
      bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd3; bus.mem_fwd_data = 32'h11;
      bus.wb_reg_write = 1'b1;  bus.wb_rd = 5'd3;  bus.wb_data = 32'h22;
      push("fwd_mem_prio", 1'b1, 1'b1, 32'h200, 32'h11, 32'h44, 32'h44, 4'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bus.mem_reg_write = 1'b0;
      push("fwd_wb", 1'b1, 1'b1, 32'h200, 32'h22, 32'h44, 32'h44, 4'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bus.stall = 1'b0;
      set_id(1'b1, 32'h204, 32'h77, 32'h44, 32'd8, 5'd0, 5'd3, 5'd11, 1'b1, 1'b1, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      push("fwd_wb_2", 1'b1, 1'b1, 32'h200, 32'h22, 32'h44, 32'h44, 4'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bus.stall = 1'b1;
      bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd0;
      set_id(1'b1, 32'h208, 32'd0, 32'd0, 32'd0, 5'd11, 5'd0, 5'd1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      push("fwd_x0_nohz", 1'b1, 1'b1, 32'h204, 32'h77, 32'd8, 32'h22, 4'd8, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bus.stall = 1'b0;
`else
      set_id(1'b1, 32'h300, 32'h12, 32'd0, 32'd0, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.stall = 1'b1;
      set_id(1'b1, 32'h304, 32'd0, 32'd0, 32'd0, 5'd4, 5'd0, 5'd1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd2; bus.mem_fwd_data = 32'h99;
      push("nofwd_ex_hz", 1'b1, 1'b1, 32'h300, 32'h12, 32'd0, 32'd0, 4'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      bus.id_rs1 = 5'd6; bus.mem_rd = 5'd6;
      push("nofwd_mem_hz", 1'b1, 1'b1, 32'h300, 32'h12, 32'd0, 32'd0, 4'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      bus.id_rs1 = 5'd0; bus.mem_rd = 5'd0;
      push("nofwd_x0", 1'b1, 1'b1, 32'h300, 32'h12, 32'd0, 32'd0, 4'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bus.id_rs1 = 5'd6; bus.mem_reg_write = 1'b0;
      bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'h99;
      push("nofwd_wb_nohz", 1'b1, 1'b1, 32'h300, 32'h12, 32'd0, 32'd0, 4'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bus.stall = 1'b0;
`endif

      // Reset while a valid instruction is held
      bus.mem_reg_write = 1'b0; bus.wb_reg_write = 1'b0;
      bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
      rst_n = 1'b0;
      tick();
      push("reset_mid", 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 4 && sb.size() > 0; i++) begin
         @(negedge clk);
      end
      #1;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending %0d expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
